// File: rtl/clint_timer_sched_pkg.sv
// Shared definitions for the CLINT timer scheduler: dbus request/response
// structures, CLINT register offsets, FSM state encoding and an address helper.
package clint_timer_sched_pkg;

    // Default byte address of the CLINT register block on the dbus.
    localparam logic [31:0] CLINT_BASE_ADDR = 32'h0200_0000;

    // Byte offsets of the timer registers inside the CLINT block.
    typedef enum logic [15:0] {
        MTIMECMP_LOW_R  = 16'h4000,
        MTIMECMP_HIGH_R = 16'h4004,
        MTIME_LOW_R     = 16'hBFF8,
        MTIME_HIGH_R    = 16'hBFFC
    } type_mtime_regs_e;

    // mtimecmp programming sequence states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_HI_MAX = 2'd1,
        WR_LO     = 2'd2,
        WR_HI     = 2'd3
    } type_tsched_state_e;

    // Master-to-peripheral dbus request.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_en;
        logic        r_en;
        logic        req;
    } type_dbus2peri_s;

    // Peripheral-to-master dbus response.
    typedef struct packed {
        logic [31:0] r_data;
        logic        err;
        logic        ack;
    } type_peri2dbus_s;

    // Absolute dbus address of a CLINT timer register.
    function automatic logic [31:0] mtime_reg_addr(input logic [31:0]      base,
                                                   input type_mtime_regs_e reg_off);
        return base + {16'h0000, reg_off};
    endfunction

endpackage

// File: rtl/clint_timer_sched_if.sv
// dbus link between the timer scheduler (master) and the CLINT (slave).
interface clint_timer_sched_if;
    import clint_timer_sched_pkg::*;

    type_dbus2peri_s sched2dbus_o;
    type_peri2dbus_s dbus2sched_i;

    modport master (output sched2dbus_o, input dbus2sched_i);
    modport slave  (input sched2dbus_o, output dbus2sched_i);

endinterface

// File: rtl/clint_timer_sched_min_sel.sv
// Combinational earliest-deadline finder. Strict less-than keeps the lowest
// index on ties; with no valid channel the minimum reads as all-ones.
module clint_timer_sched_min_sel #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] valid_i,
    input  logic [63:0]       deadline_i [NUM_CH],
    output logic [63:0]       min_o,
    output logic              any_valid_o
);

    // Linear scan for the smallest valid deadline.
    always_comb begin
        min_o       = 64'hFFFF_FFFF_FFFF_FFFF;
        any_valid_o = |valid_i;
        for (int i = 0; i < NUM_CH; i++) begin
            min_o = (valid_i[i] && (deadline_i[i] < min_o)) ? deadline_i[i] : min_o;
        end
    end

endmodule

// File: rtl/clint_timer_sched.sv
// Multi-channel timer scheduler owning the CLINT mtimecmp register. Keeps
// NUM_CH absolute deadlines, programs the earliest one into mtimecmp with a
// glitch-free 32-bit write sequence and flags channels that have expired.
module clint_timer_sched
    import clint_timer_sched_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter logic [31:0] CLINT_BASE = CLINT_BASE_ADDR
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arm_i,
    input  logic [$clog2(NUM_CH)-1:0] arm_id_i,
    input  logic [63:0]               arm_deadline_i,
    input  logic                      cancel_i,
    input  logic [$clog2(NUM_CH)-1:0] cancel_id_i,
    input  logic [NUM_CH-1:0]         pend_clr_i,
    input  logic [63:0]               mtime_i,
    clint_timer_sched_if.master       dbus_if,
    output logic [NUM_CH-1:0]         pending_o,
    output logic                      sched_irq_o,
    output logic                      busy_o
);

    localparam int IDW = $clog2(NUM_CH);

    // Channel state
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [63:0]       dl_q [NUM_CH];
    logic [63:0]       dl_d [NUM_CH];
    logic              irq_q;
    logic [NUM_CH-1:0] arm_hit_s, cancel_hit_s, expire_s;

    // Programming sequence state
    type_tsched_state_e state_q, state_d;
    logic [63:0]        shadow_q, shadow_d;
    logic [63:0]        prog_cmp_q, prog_cmp_d;
    logic               full_seq_q, full_seq_d;
    logic [63:0]        min_s, target_s;
    logic               any_valid_s;
    logic               ack_s;

    // Registered dbus request
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    assign ack_s = dbus_if.dbus2sched_i.ack;

    clint_timer_sched_min_sel #(.NUM_CH(NUM_CH)) u_min_sel (
        .valid_i     (valid_q),
        .deadline_i  (dl_q),
        .min_o       (min_s),
        .any_valid_o (any_valid_s)
    );

    assign target_s = any_valid_s ? min_s : 64'hFFFF_FFFF_FFFF_FFFF;

    // Per-channel decode of arm/cancel targets and deadline expiry.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            arm_hit_s[i]    = arm_i && (arm_id_i == IDW'(i));
            cancel_hit_s[i] = cancel_i && (cancel_id_i == IDW'(i));
            expire_s[i]     = valid_q[i] && (dl_q[i] <= mtime_i);
        end
    end

    // Channel next state: arm beats expiry and cancel, expiry beats pending clear.
    always_comb begin
        valid_d = valid_q;
        pend_d  = pend_q;
        dl_d    = dl_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arm_hit_s[i]) begin
                valid_d[i] = 1'b1;
                dl_d[i]    = arm_deadline_i;
                pend_d[i]  = 1'b0;
            end else if (expire_s[i]) begin
                valid_d[i] = 1'b0;
                pend_d[i]  = 1'b1;
            end else begin
                valid_d[i] = valid_q[i] & ~cancel_hit_s[i];
                pend_d[i]  = pend_q[i] & ~pend_clr_i[i];
            end
        end
    end

    // Channel registers and registered interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                dl_q[i] <= 64'h0;
            end
        end else begin
            valid_q <= valid_d;
            pend_q  <= pend_d;
            irq_q   <= |pend_q;
            dl_q    <= dl_d;
        end
    end

    // Sequencer: parking HIGH at all-ones while LOW changes keeps mtimecmp
    // from ever passing through a spurious earlier value.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        prog_cmp_d = prog_cmp_q;
        full_seq_d = full_seq_q;
        case (state_q)
            IDLE: begin
                if (target_s != prog_cmp_q) begin
                    shadow_d = target_s;
                    if (target_s[63:32] == prog_cmp_q[63:32]) begin
                        full_seq_d = 1'b0;
                        state_d    = WR_LO;
                    end else begin
                        full_seq_d = 1'b1;
                        state_d    = WR_HI_MAX;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_HI_MAX: begin
                if (ack_s) begin
                    state_d = WR_LO;
                end else begin
                    state_d = WR_HI_MAX;
                end
            end
            WR_LO: begin
                if (ack_s && full_seq_q) begin
                    state_d = WR_HI;
                end else if (ack_s) begin
                    prog_cmp_d = shadow_q;
                    state_d    = IDLE;
                end else begin
                    state_d = WR_LO;
                end
            end
            WR_HI: begin
                if (ack_s) begin
                    prog_cmp_d = shadow_q;
                    state_d    = IDLE;
                end else begin
                    state_d = WR_HI;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields for the state being entered, so the bus sees them from a register.
    always_comb begin
        req_d   = 1'b0;
        addr_d  = 32'h0;
        wdata_d = 32'h0;
        case (state_d)
            WR_HI_MAX: begin
                req_d   = 1'b1;
                addr_d  = mtime_reg_addr(CLINT_BASE, MTIMECMP_HIGH_R);
                wdata_d = 32'hFFFF_FFFF;
            end
            WR_LO: begin
                req_d   = 1'b1;
                addr_d  = mtime_reg_addr(CLINT_BASE, MTIMECMP_LOW_R);
                wdata_d = shadow_d[31:0];
            end
            WR_HI: begin
                req_d   = 1'b1;
                addr_d  = mtime_reg_addr(CLINT_BASE, MTIMECMP_HIGH_R);
                wdata_d = shadow_d[63:32];
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // Sequencer and request registers; prog_cmp resets to the CLINT mtimecmp reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shadow_q   <= 64'h0;
            prog_cmp_q <= 64'h0;
            full_seq_q <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            prog_cmp_q <= prog_cmp_d;
            full_seq_q <= full_seq_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Drive the dbus request; unused fields stay zero.
    always_comb begin
        dbus_if.sched2dbus_o        = '0;
        dbus_if.sched2dbus_o.req    = req_q;
        dbus_if.sched2dbus_o.w_en   = req_q;
        dbus_if.sched2dbus_o.addr   = addr_q;
        dbus_if.sched2dbus_o.w_data = wdata_q;
    end

    assign pending_o   = pend_q;
    assign sched_irq_o = irq_q;
    assign busy_o      = (state_q != IDLE);

endmodule
